// File: rtl/mem_block_arbiter.sv
// mem_block_arbiter: two-requester arbiter/sequencer for the SoC memory blocks.
//
// Requester 0 (instruction fetch) and requester 1 (data/bus bridge) compete
// for one shared memory-block port. A winner is picked in IDLE and its
// request is latched. The address is decoded to ROM/RAM/SRAM. The block is
// held in ACCESS until its wait drops or the watchdog expires. Completion is
// reported for one cycle in DONE.
//
// Optional feature (macro MEM_ARB_ROUND_ROBIN_EN):
//   defined   - round-robin tie-break: the requester not granted last wins
//   undefined - fixed priority: requester 0 always wins a tie
//
// Ports:
//   CLK, nRST                        clock, async active-low reset
//   req/wen/addr/wdata/byte_en{0,1}  requester inputs, held until done
//   rdata/done/err{0,1}              per-requester completion (one-cycle pulse)
//   wen/addr/wdata/byte_en           shared memory-block request, stable in ACCESS
//   sram_sel/ram_sel/rom_sel         one-hot region select, high only in ACCESS
//   {sram,ram,rom}_rdata/_wait       per-block read data and wait
module mem_block_arbiter #(
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter logic [31:0] ROM_SIZE  = 32'h0000_8000,
  parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
  parameter logic [31:0] RAM_SIZE  = 32'h0001_0000,
  parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] SRAM_SIZE = 32'h0010_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req0,
  input  logic        req1,
  input  logic        wen0,
  input  logic        wen1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  byte_en0,
  input  logic [3:0]  byte_en1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        wen,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic        sram_sel,
  output logic        ram_sel,
  output logic        rom_sel,
  input  logic [31:0] sram_rdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] rom_rdata,
  input  logic        sram_wait,
  input  logic        ram_wait,
  input  logic        rom_wait
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
  typedef enum logic [1:0] {RG_NONE, RG_ROM, RG_RAM, RG_SRAM} region_t;

  state_t           state_q, state_d;
  region_t          region_q, region_d;
  logic             gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wen_d;
  logic [31:0]      addr_d, wdata_d;
  logic [3:0]       byte_en_d;
  logic             sram_sel_d, ram_sel_d, rom_sel_d;
  logic             done0_d, done1_d, err0_d, err1_d;
  logic [31:0]      rdata0_d, rdata1_d;

  // Completion event computed by the FSM, routed to the granted requester.
  logic             fin;
  logic             fin_err;
  logic [31:0]      fin_rdata;

  logic             pick;
  logic             req_wen;
  logic [31:0]      req_addr, req_wdata;
  logic [3:0]       req_byte_en;
  region_t          req_region;
  logic             blk_wait;
  logic [31:0]      blk_rdata;

  // Range check by offset from base; robust for any base since sizes are
  // unsigned and the subtraction wraps.
  function automatic region_t decode(input logic [31:0] a);
    if ((a - ROM_BASE) < ROM_SIZE)        return RG_ROM;
    else if ((a - RAM_BASE) < RAM_SIZE)   return RG_RAM;
    else if ((a - SRAM_BASE) < SRAM_SIZE) return RG_SRAM;
    else                                  return RG_NONE;
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q = 1 favours requester 1 on a tie.
  logic rr_q, rr_d;
  assign pick = req1 & (~req0 | rr_q);
`else
  assign pick = req1 & ~req0;
`endif

  // Winning request, before latching.
  assign req_wen     = pick ? wen1     : wen0;
  assign req_addr    = pick ? addr1    : addr0;
  assign req_wdata   = pick ? wdata1   : wdata0;
  assign req_byte_en = pick ? byte_en1 : byte_en0;
  assign req_region  = decode(req_addr);

  // Wait/data of the block selected by the latched region.
  always_comb begin
    blk_wait  = 1'b0;
    blk_rdata = '0;
    unique case (region_q)
      RG_ROM:  begin blk_wait = rom_wait;  blk_rdata = rom_rdata;  end
      RG_RAM:  begin blk_wait = ram_wait;  blk_rdata = ram_rdata;  end
      RG_SRAM: begin blk_wait = sram_wait; blk_rdata = sram_rdata; end
      RG_NONE: begin blk_wait = 1'b0;      blk_rdata = '0;         end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    wen_d      = wen;
    addr_d     = addr;
    wdata_d    = wdata;
    byte_en_d  = byte_en;
    sram_sel_d = sram_sel;
    ram_sel_d  = ram_sel;
    rom_sel_d  = rom_sel;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_rdata  = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d    = pick;
          region_d = req_region;
          if (req_region == RG_NONE || (req_region == RG_ROM && req_wen)) begin
            // Unmapped or ROM write: fail without touching any block.
            state_d = ST_DONE;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d    = ST_ACCESS;
            wen_d      = req_wen;
            addr_d     = req_addr;
            wdata_d    = req_wdata;
            byte_en_d  = req_byte_en;
            rom_sel_d  = (req_region == RG_ROM);
            ram_sel_d  = (req_region == RG_RAM);
            sram_sel_d = (req_region == RG_SRAM);
          end
        end
      end

      ST_ACCESS: begin
        if (!blk_wait) begin
          state_d   = ST_DONE;
          fin       = 1'b1;
          fin_rdata = wen ? 32'h0 : blk_rdata;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog: block held wait for TIMEOUT cycles.
          state_d = ST_DONE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (fin) begin
          wen_d      = 1'b0;
          addr_d     = '0;
          wdata_d    = '0;
          byte_en_d  = '0;
          sram_sel_d = 1'b0;
          ram_sel_d  = 1'b0;
          rom_sel_d  = 1'b0;
        end
      end

      ST_DONE: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        region_d = RG_NONE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_d     = ~gnt_q;
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    done0_d  = fin & ~gnt_d;
    done1_d  = fin &  gnt_d;
    err0_d   = fin_err & ~gnt_d;
    err1_d   = fin_err &  gnt_d;
    rdata0_d = gnt_d ? 32'h0 : fin_rdata;
    rdata1_d = gnt_d ? fin_rdata : 32'h0;
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      region_q <= RG_NONE;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      wen      <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      byte_en  <= '0;
      sram_sel <= 1'b0;
      ram_sel  <= 1'b0;
      rom_sel  <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      wen      <= wen_d;
      addr     <= addr_d;
      wdata    <= wdata_d;
      byte_en  <= byte_en_d;
      sram_sel <= sram_sel_d;
      ram_sel  <= ram_sel_d;
      rom_sel  <= rom_sel_d;
      done0    <= done0_d;
      done1    <= done1_d;
      err0     <= err0_d;
      err1     <= err1_d;
      rdata0   <= rdata0_d;
      rdata1   <= rdata1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q     <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Testbench for mem_block_arbiter: directed vector table, hand-written
// contention and reset sequences, and randomized transactions checked
// against a transaction-level reference model.
module tb_mem_block_arbiter;

  localparam int unsigned TO = 8;
  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE  = 32'h0000_8000;
  localparam logic [31:0] RAM_BASE  = 32'h2000_0000;
  localparam logic [31:0] RAM_SIZE  = 32'h0001_0000;
  localparam logic [31:0] SRAM_BASE = 32'h8000_0000;
  localparam logic [31:0] SRAM_SIZE = 32'h0010_0000;

  logic        CLK, nRST;
  logic        req0, req1, wen0, wen1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  byte_en0, byte_en1;
  logic [31:0] rdata0, rdata1;
  logic        done0, done1, err0, err1;
  logic        wen;
  logic [31:0] addr, wdata;
  logic [3:0]  byte_en;
  logic        sram_sel, ram_sel, rom_sel;
  logic [31:0] sram_rdata, ram_rdata, rom_rdata;
  logic        sram_wait, ram_wait, rom_wait;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;   // cycles the current select has been high
  int wcfg = 0;      // block holds wait for this many access cycles
  int last_gnt = 1;  // model: requester granted last (1 => favour 0)
  int exp_g[4];

  mem_block_arbiter #(
    .ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE),
    .RAM_BASE(RAM_BASE), .RAM_SIZE(RAM_SIZE),
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE),
    .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .byte_en0(byte_en0), .byte_en1(byte_en1),
    .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .wen(wen), .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .sram_sel(sram_sel), .ram_sel(ram_sel), .rom_sel(rom_sel),
    .sram_rdata(sram_rdata), .ram_rdata(ram_rdata), .rom_rdata(rom_rdata),
    .sram_wait(sram_wait), .ram_wait(ram_wait), .rom_wait(rom_wait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory-block behaviour: wait for the first wcfg cycles of an access.
  always @(posedge CLK) acc_cnt <= (sram_sel | ram_sel | rom_sel) ? acc_cnt + 1 : 0;
  assign sram_wait = (acc_cnt < wcfg);
  assign ram_wait  = (acc_cnt < wcfg);
  assign rom_wait  = (acc_cnt < wcfg);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (idx == 0) begin req0 = r; wen0 = w; addr0 = a; wdata0 = d; byte_en0 = be; end
    else          begin req1 = r; wen1 = w; addr1 = a; wdata1 = d; byte_en1 = be; end
  endtask

  // Requester changes its inputs mid-access; the shared bus must not follow.
  task automatic scramble(input int idx);
    if (idx == 0) begin addr0 = ~addr0; wdata0 = $urandom; byte_en0 = ~byte_en0; wen0 = ~wen0; end
    else          begin addr1 = ~addr1; wdata1 = $urandom; byte_en1 = ~byte_en1; wen1 = ~wen1; end
  endtask

  // Model: region index 0=none 1=rom 2=ram 3=sram by plain interval compare.
  function automatic int region_of(input logic [31:0] a);
    longint la;
    la = longint'(a);
    if (la >= longint'(ROM_BASE) && la < longint'(ROM_BASE) + longint'(ROM_SIZE)) return 1;
    if (la >= longint'(RAM_BASE) && la < longint'(RAM_BASE) + longint'(RAM_SIZE)) return 2;
    if (la >= longint'(SRAM_BASE) && la < longint'(SRAM_BASE) + longint'(SRAM_SIZE)) return 3;
    return 0;
  endfunction

  task automatic predict(input logic [31:0] a, input bit w, output bit e_err,
                         output logic [31:0] e_rd, output int nsel, output logic [2:0] e_sel);
    int r;
    r = region_of(a);
    e_err = 1'b0; e_rd = 32'h0; nsel = 0; e_sel = 3'b000;
    if (r == 0 || (r == 1 && w)) begin
      e_err = 1'b1;
    end else begin
      e_sel = (r == 1) ? 3'b001 : (r == 2) ? 3'b010 : 3'b100;
      if (wcfg >= int'(TO)) begin
        nsel = TO; e_err = 1'b1;
      end else begin
        nsel = wcfg + 1;
        e_rd = w ? 32'h0 : (r == 1) ? rom_rdata : (r == 2) ? ram_rdata : sram_rdata;
      end
    end
  endtask

  // Called at posedge+1 of an IDLE cycle with requests already applied.
  task automatic run_txn(input int g, input bit e_err, input logic [31:0] e_rd, input int nsel,
                         input logic [2:0] e_sel, input bit e_wen, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic [3:0] e_be,
                         input bit keep, input bit scr, input string tag);
    @(posedge CLK);
    for (int k = 0; k < nsel; k++) begin
      @(negedge CLK);
      chk({tag, " sel"}, {29'b0, sram_sel, ram_sel, rom_sel}, {29'b0, e_sel});
      chk({tag, " wen"}, {31'b0, wen}, {31'b0, e_wen});
      chk({tag, " addr"}, addr, e_addr);
      chk({tag, " wdata"}, wdata, e_wdata);
      chk({tag, " byte_en"}, {28'b0, byte_en}, {28'b0, e_be});
      chk({tag, " early done"}, {30'b0, done1, done0}, 32'h0);
      if (scr && k == 0) scramble(g);
    end
    @(negedge CLK);
    chk({tag, " sel in done"}, {29'b0, sram_sel, ram_sel, rom_sel}, 32'h0);
    if (g == 0) begin
      chk({tag, " done0"}, {31'b0, done0}, 32'h1);
      chk({tag, " err0"}, {31'b0, err0}, {31'b0, e_err});
      chk({tag, " rdata0"}, rdata0, e_rd);
      chk({tag, " idle req1"}, {30'b0, done1, err1} | rdata1, 32'h0);
    end else begin
      chk({tag, " done1"}, {31'b0, done1}, 32'h1);
      chk({tag, " err1"}, {31'b0, err1}, {31'b0, e_err});
      chk({tag, " rdata1"}, rdata1, e_rd);
      chk({tag, " idle req0"}, {30'b0, done0, err0} | rdata0, 32'h0);
    end
    @(posedge CLK);
    #1;
    if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
    last_gnt = g;
  endtask

  function automatic logic [31:0] gen_addr();
    case ($urandom_range(0, 5))
      0: return ROM_BASE + 32'($urandom_range(0, ROM_SIZE - 1));
      1: return RAM_BASE + 32'($urandom_range(0, RAM_SIZE - 1));
      2: return SRAM_BASE + 32'($urandom_range(0, SRAM_SIZE - 1));
      3: return 32'h4000_0000 + 32'($urandom_range(0, 32'hFFFF));
      4: return RAM_BASE + RAM_SIZE + 32'($urandom_range(0, 15));
      default: return SRAM_BASE - 32'($urandom_range(1, 16));
    endcase
  endfunction

  typedef struct {
    int          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          wc;
    bit          e_err;
    logic [31:0] e_rd;
    int          e_nsel;
    logic [2:0]  e_sel;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{0, 1'b0, 32'h2000_0010, 32'h0,         4'hF,   0, 1'b0, 32'hDEAD_BEEF, 1, 3'b010};
    vt[1]  = '{1, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 5, 1'b0, 32'h0,        6, 3'b100};
    vt[2]  = '{0, 1'b0, 32'h4000_0000, 32'h0,         4'hF,   0, 1'b1, 32'h0,         0, 3'b000};
    vt[3]  = '{0, 1'b1, 32'h0000_0100, 32'hAAAA_5555, 4'hF,   0, 1'b1, 32'h0,         0, 3'b000};
    vt[4]  = '{0, 1'b0, 32'h0000_0200, 32'h0,         4'hF, 100, 1'b1, 32'h0,         8, 3'b001};
    vt[5]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         4'hF,   2, 1'b0, 32'hC0DE_0001, 3, 3'b001};
    vt[6]  = '{1, 1'b0, 32'h0000_7FFC, 32'h0,         4'hF,   0, 1'b0, 32'hC0DE_0001, 1, 3'b001};
    vt[7]  = '{1, 1'b0, 32'h0000_8000, 32'h0,         4'hF,   0, 1'b1, 32'h0,         0, 3'b000};
    vt[8]  = '{0, 1'b1, 32'h2000_FFFF, 32'h0BAD_F00D, 4'b1000, 7, 1'b0, 32'h0,        8, 3'b010};
    vt[9]  = '{1, 1'b0, 32'h2001_0000, 32'h0,         4'hF,   0, 1'b1, 32'h0,         0, 3'b000};
    vt[10] = '{0, 1'b0, 32'h800F_FFFC, 32'h0,         4'hF,   8, 1'b1, 32'h0,         8, 3'b100};
    vt[11] = '{1, 1'b0, 32'h8010_0000, 32'h0,         4'hF,   0, 1'b1, 32'h0,         0, 3'b000};
    vt[12] = '{0, 1'b1, 32'h1FFF_FFFF, 32'h0,         4'hF,   0, 1'b1, 32'h0,         0, 3'b000};
    vt[13] = '{1, 1'b0, 32'h8000_0000, 32'h0,         4'hF,   3, 1'b0, 32'h5A5A_A5A5, 4, 3'b100};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    nRST = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rom_rdata = 32'hC0DE_0001; ram_rdata = 32'hDEAD_BEEF; sram_rdata = 32'h5A5A_A5A5;
    wcfg = 0;
    #22;
    chk("reset done/err", {28'b0, done0, done1, err0, err1}, 32'h0);
    chk("reset rdata", rdata0 | rdata1, 32'h0);
    chk("reset sel", {29'b0, sram_sel, ram_sel, rom_sel}, 32'h0);
    chk("reset bus", addr | wdata | {27'b0, wen, byte_en}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      wcfg = vt[i].wc;
      set_req(vt[i].r, 1'b1, vt[i].w, vt[i].a, vt[i].d, vt[i].be);
      run_txn(vt[i].r, vt[i].e_err, vt[i].e_rd, vt[i].e_nsel, vt[i].e_sel,
              vt[i].w, vt[i].a, vt[i].d, vt[i].be, 1'b0, 1'b1, $sformatf("vec%0d", i));
    end

    // Contention: both requesters held high across four accesses.
    wcfg = 1;
    set_req(0, 1'b1, 1'b0, 32'h2000_0020, 32'h1111_1111, 4'hF);
    set_req(1, 1'b1, 1'b1, 32'h8000_0040, 32'h2222_2222, 4'h3);
    for (int j = 0; j < 4; j++) begin
      if (exp_g[j] == 0)
        run_txn(0, 1'b0, 32'hDEAD_BEEF, 2, 3'b010, 1'b0, 32'h2000_0020, 32'h1111_1111,
                4'hF, 1'b1, 1'b0, $sformatf("cont%0d", j));
      else
        run_txn(1, 1'b0, 32'h0, 2, 3'b100, 1'b1, 32'h8000_0040, 32'h2222_2222,
                4'h3, 1'b1, 1'b0, $sformatf("cont%0d", j));
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the middle of a stretched SRAM access.
    wcfg = 100;
    set_req(0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid sel before", {31'b0, sram_sel}, 32'h1);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_mid sel", {29'b0, sram_sel, ram_sel, rom_sel}, 32'h0);
    chk("rst_mid done/err", {28'b0, done0, done1, err0, err1}, 32'h0);
    chk("rst_mid bus", addr | wdata | {27'b0, wen, byte_en}, 32'h0);
    chk("rst_mid rdata", rdata0 | rdata1, 32'h0);
    req0 = 1'b0;
    wcfg = 0;
    @(posedge CLK);
    #1;
    chk("rst_mid no done", {30'b0, done0, done1}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    last_gnt = 1;
    set_req(0, 1'b1, 1'b0, 32'h2000_0100, 32'h0, 4'hF);
    run_txn(0, 1'b0, 32'hDEAD_BEEF, 1, 3'b010, 1'b0, 32'h2000_0100, 32'h0, 4'hF,
            1'b0, 1'b0, "post_rst");

    // Randomized transactions against the reference model.
    for (int n = 0; n < 80; n++) begin
      int          rq, g;
      bit          e_err;
      logic [31:0] e_rd, ga, gd;
      logic [3:0]  gb;
      bit          gw;
      int          nsel;
      logic [2:0]  e_sel;
      rq = int'($urandom_range(1, 3));
      set_req(0, rq[0], 1'($urandom_range(0, 1)), gen_addr(), $urandom, 4'($urandom));
      set_req(1, rq[1], 1'($urandom_range(0, 1)), gen_addr(), $urandom, 4'($urandom));
      wcfg = int'($urandom_range(0, 10));
      rom_rdata = $urandom; ram_rdata = $urandom; sram_rdata = $urandom;
      if (rq == 3) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        g = (last_gnt == 0) ? 1 : 0;
`else
        g = 0;
`endif
      end else begin
        g = (rq == 2) ? 1 : 0;
      end
      if (g == 0) begin gw = wen0; ga = addr0; gd = wdata0; gb = byte_en0; end
      else        begin gw = wen1; ga = addr1; gd = wdata1; gb = byte_en1; end
      predict(ga, gw, e_err, e_rd, nsel, e_sel);
      run_txn(g, e_err, e_rd, nsel, e_sel, gw, ga, gd, gb, 1'b0, 1'b1,
              $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_block_arbiter.md
Name: mem_block_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the SoC memory blocks (SRAM, RAM, ROM).
- Accepts requests from requester 0 (instruction fetch) and requester 1 (data/bus bridge), and grants one at a time.
- Decodes the address to a region, drives the shared memory-block signals and holds them stable while the block asserts wait.
- Returns read data and error status to the granted requester, with a wait-timeout watchdog.

Parameters:
- ROM_BASE, 32'h0000_0000, ROM region base (byte address)
- ROM_SIZE, 32'h0000_8000, ROM region size in bytes, power of two
- RAM_BASE, 32'h2000_0000, RAM region base
- RAM_SIZE, 32'h0001_0000, RAM region size, power of two
- SRAM_BASE, 32'h8000_0000, off-chip SRAM region base
- SRAM_SIZE, 32'h0010_0000, SRAM region size, power of two
- TIMEOUT, 255, max cycles a block may hold wait before the access is aborted with error (1..65535)

Ports:
- CLK  in  1  system clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- req0, req1  in  1 each  request valid; held until the matching done
- wen0, wen1  in  1 each  1 = write, 0 = read
- addr0, addr1  in  32 each  byte address
- wdata0, wdata1  in  32 each  write data
- byte_en0, byte_en1  in  4 each  byte lane enables
- rdata0, rdata1  out  32 each  read data, valid while the matching done is high
- done0, done1  out  1 each  one-cycle completion pulse
- err0, err1  out  1 each  error flag, valid with done
- wen, addr, wdata, byte_en  out  1/32/32/4  shared memory-block request signals
- sram_sel, ram_sel, rom_sel  out  1 each  one-hot region select, high only in ACCESS
- sram_rdata, ram_rdata, rom_rdata  in  32 each  per-block read data
- sram_wait, ram_wait, rom_wait  in  1 each  per-block wait; data/ack valid when low

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE; all outputs 0; latched request cleared; timeout counter 0; round-robin pointer favours requester 0.
- IDLE state:
  - Sample req0/req1 and pick a winner.
  - Latch the winner's wen/addr/wdata/byte_en and the grant index.
  - Decode the region: ROM if addr in [ROM_BASE, ROM_BASE+ROM_SIZE); likewise RAM and SRAM; otherwise unmapped.
  - If unmapped, or a ROM write: go to DONE with err=1, no select asserted.
  - Otherwise go to ACCESS.
  - No request: stay in IDLE.
- ACCESS state:
  - Drive wen/addr/wdata/byte_en from the latched registers; exactly one select high.
  - If the selected block's wait=0: capture its rdata (writes capture 0) and go to DONE with err=0.
  - If wait=1: increment the counter. When counter==TIMEOUT-1 with wait still 1, go to DONE with err=1 and rdata=0.
- DONE state:
  - One cycle; the granted requester's done=1 with rdata/err; the other requester's outputs stay 0.
  - No new requests are sampled; go to IDLE.
  - Counter clears. The round-robin pointer updates to favour the non-granted requester.
- Latency: req sampled in cycle N → ACCESS in N+1 → done in N+2 at minimum (zero-wait block). An unmapped or ROM-write access completes in N+1.
- Requester rule: deassert or change req in the cycle after done; a still-asserted req in the following IDLE starts a new access.
- Shared outputs are stable for the whole ACCESS state even if the requester's inputs change.
- Simultaneous req0 and req1: resolved by arbitration policy (see Optional Feature). The loser waits, with no done and no data loss.
- Reset mid-ACCESS: aborts immediately with selects low and no done; the requester must reissue.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin; on a tie the requester not granted last wins.
- Undefined: fixed priority, requester 0 always wins a tie; pointer logic omitted.

Test Plan:
- Read, zero wait: req0=1, addr0=32'h2000_0010, ram_wait=0, ram_rdata=32'hDEAD_BEEF → ram_sel=1 in cycle 1; done0=1, rdata0=32'hDEAD_BEEF, err0=0 in cycle 2; no activity on requester 1.
- Write, wait stretch: req1=1, wen1=1, addr1=32'h8000_0004, wdata1=32'h1234_5678, byte_en1=4'b0011, sram_wait high for 5 cycles → shared bus stable with sram_sel=1 for 6 cycles; done1 one cycle after wait falls; err1=0.
- Error paths:
  - addr0=32'h4000_0000 → done0=1, err0=1 one cycle after sampling, no select asserted.
  - wen0=1 to ROM address 32'h0000_0100 → same err/done response, no select asserted.
- Timeout: TIMEOUT=8, rom_wait stuck at 1 → rom_sel high exactly 8 cycles, then done0=1, err0=1, rdata0=0; the next request is serviced normally.
- Contention: req0 and req1 held high continuously for 4 accesses:
  - With MEM_ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
  - Without it: grants are 0,0,0,0 and requester 1 is never granted.
- Reset mid-ACCESS: drop nRST while sram_wait=1 → all outputs 0 asynchronously, state IDLE, no done; a request after release completes normally.
